// File: rtl/seq_detect_multi.sv
// Serial MSB-first detector for NUM_PAT patterns with registered hit pulses.
// Define HIT_CNT_EN to add per-pattern saturating hit counters.
module seq_detect_multi #(
  parameter int SEQ_WIDTH = 6,
  parameter int NUM_PAT   = 2,
  parameter logic [NUM_PAT*SEQ_WIDTH-1:0] TARGETS =
    {6'b101110, 6'b111000},
  parameter bit OVERLAP   = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     din,
  input  logic                     din_vld,
  output logic [NUM_PAT-1:0]       hit,
  output logic                     result,
  output logic [NUM_PAT*CNT_W-1:0] hit_cnt
);

  localparam int FW = $clog2(SEQ_WIDTH + 1);
  localparam logic [FW-1:0] FULL = FW'(SEQ_WIDTH);

  logic [SEQ_WIDTH-1:0] win_q, win_d, new_win;
  logic [FW-1:0]        fill_q, fill_d, fill_inc;
  logic [NUM_PAT-1:0]   match, hit_d;
  logic                 eligible;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q  <= '0;
      fill_q <= '0;
      hit    <= '0;
      result <= 1'b0;
    end else begin
      win_q  <= win_d;
      fill_q <= fill_d;
      hit    <= hit_d;
      result <= |hit_d;
    end
  end

  always_comb begin
    new_win  = {win_q[SEQ_WIDTH-2:0], din};
    fill_inc = (fill_q == FULL) ? fill_q : fill_q + FW'(1);
    eligible = (fill_inc == FULL);
    for (int i = 0; i < NUM_PAT; i++) begin
      match[i] = eligible &&
        (new_win == TARGETS[i*SEQ_WIDTH +: SEQ_WIDTH]);
    end
  end

  // clr drops the bit presented on its edge
  always_comb begin
    win_d  = win_q;
    fill_d = fill_q;
    hit_d  = '0;
    if (clr) begin
      win_d  = '0;
      fill_d = '0;
    end else if (din_vld) begin
      win_d  = new_win;
      hit_d  = match;
      fill_d = (!OVERLAP && |match) ? '0 : fill_inc;
    end
  end

`ifdef HIT_CNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_PAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PAT; i++) cnt_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NUM_PAT; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PAT; i++) begin
        if (hit_d[i] && !(&cnt_q[i]))
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < NUM_PAT; i++)
      hit_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end
`else
  assign hit_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_multi.sv
// Directed bench for seq_detect_multi: overlap and non-overlap
// instances share stimulus; counters checked when HIT_CNT_EN is set.
module tb_seq_detect_multi;

  logic       clk = 1'b0;
  logic       rst, clr, din, din_vld;
  logic [1:0] hit, hit_n;
  logic       result, result_n;
  logic [3:0] cnt, cnt_n;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_detect_multi #(.CNT_W(2)) dut (
    .clk(clk), .rst(rst), .clr(clr), .din(din),
    .din_vld(din_vld), .hit(hit), .result(result),
    .hit_cnt(cnt)
  );

  seq_detect_multi #(.OVERLAP(1'b0), .CNT_W(2)) dut_n (
    .clk(clk), .rst(rst), .clr(clr), .din(din),
    .din_vld(din_vld), .hit(hit_n), .result(result_n),
    .hit_cnt(cnt_n)
  );

  typedef struct {
    string      name;
    logic       clr;
    logic       din;
    logic       vld;
    logic [1:0] eh;
    logic [1:0] eh_n;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic c,
                     input logic d, input logic v,
                     input logic [1:0] eh,
                     input logic [1:0] eh_n);
    vec_t t;
    t.name = nm; t.clr = c; t.din = d; t.vld = v;
    t.eh = eh; t.eh_n = eh_n;
    tv.push_back(t);
  endtask

  task automatic step(input logic c, input logic d,
                      input logic v);
    clr = c; din = d; din_vld = v;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    #2 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  task automatic run_table();
    foreach (tv[k]) begin
      if (tv[k].name == "RST") begin
        pulse_rst();
      end else begin
        step(tv[k].clr, tv[k].din, tv[k].vld);
        chk({tv[k].name, ".hit"}, 32'(hit), 32'(tv[k].eh));
        chk({tv[k].name, ".hit_n"}, 32'(hit_n), 32'(tv[k].eh_n));
        chk({tv[k].name, ".res"}, 32'(result), 32'(|tv[k].eh));
      end
    end
  endtask

  initial begin
    logic [17:0] s1;
    logic [5:0]  p0;
    logic [1:0]  e;
    logic [1:0]  en;
    int          nh;

    rst = 1'b1; clr = 1'b0; din = 1'b0; din_vld = 1'b0;
    #3;
    chk("reset.hit", 32'(hit), 0);
    chk("reset.res", 32'(result), 0);
    chk("reset.cnt", 32'(cnt), 0);
    chk("reset.hit_n", 32'(hit_n), 0);
    #4 rst = 1'b0;

    // Long stream with overlap vs restart behaviour
    s1 = 18'b001110001101110000;
    for (int i = 0; i < 18; i++) begin
      e  = 2'b00;
      en = 2'b00;
      if (i == 7)  begin e = 2'b01; en = 2'b01; end
      if (i == 14) begin e = 2'b10; en = 2'b10; end
      if (i == 16) e = 2'b01;
      add("stream", 1'b0, s1[17-i], 1'b1, e, en);
    end

    // Valid gap inside a pattern
    add("RST", 0, 0, 0, 0, 0);
    p0 = 6'b111000;
    for (int i = 0; i < 5; i++)
      add("gap_pre", 1'b0, p0[5-i], 1'b1, 2'b00, 2'b00);
    for (int i = 0; i < 4; i++)
      add("gap", 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
    add("gap_end", 1'b0, 1'b0, 1'b1, 2'b01, 2'b01);

    // Short fill, then clr drops its bit
    add("RST", 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      add("fill", 1'b0, p0[5-i], 1'b1, 2'b00, 2'b00);
    add("clr_bit", 1'b1, 1'b0, 1'b1, 2'b00, 2'b00);
    for (int i = 0; i < 6; i++)
      add("post_clr", 1'b0, p0[5-i], 1'b1,
          (i == 5) ? 2'b01 : 2'b00, (i == 5) ? 2'b01 : 2'b00);

    run_table();

    // Async reset while a hit is showing
    pulse_rst();
    for (int i = 0; i < 6; i++) step(1'b0, p0[5-i], 1'b1);
    chk("pre_rst.hit", 32'(hit), 1);
    #2 rst = 1'b1;
    #1;
    chk("async.hit", 32'(hit), 0);
    chk("async.res", 32'(result), 0);
    rst = 1'b0;

    // Async reset mid-pattern loses the partial bits
    for (int i = 0; i < 4; i++) step(1'b0, p0[5-i], 1'b1);
    pulse_rst();
    for (int i = 4; i < 6; i++) begin
      step(1'b0, p0[5-i], 1'b1);
      chk("lost.hit", 32'(hit), 0);
      chk("lost.hit_n", 32'(hit_n), 0);
    end

    // Five separate patterns, 2-bit saturating counter
    pulse_rst();
    for (int k = 1; k <= 5; k++) begin
      for (int i = 0; i < 6; i++) step(1'b0, p0[5-i], 1'b1);
      nh = (k > 3) ? 3 : k;
      chk("cnt.hit", 32'(hit), 1);
      chk("cnt.hit_n", 32'(hit_n), 1);
`ifdef HIT_CNT_EN
      chk("cnt.p0", 32'(cnt[1:0]), 32'(nh));
      chk("cnt.p0_n", 32'(cnt_n[1:0]), 32'(nh));
`else
      chk("cnt.p0", 32'(cnt[1:0]), 0);
      chk("cnt.p0_n", 32'(cnt_n[1:0]), 0);
`endif
      chk("cnt.p1", 32'(cnt[3:2]), 0);
    end
    step(1'b1, 1'b0, 1'b0);
    chk("cnt.clr", 32'(cnt), 0);
    chk("cnt.clr_n", 32'(cnt_n), 0);
    chk("cnt.clr_hit", 32'(hit), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
